// File: rtl/download_router.sv
// download_router: buffered, stallable data_io download path into memory with a PRG end-pointer patch.
// Define DOWNLOAD_PTR_PATCH_EN to include the PATCH state; without it PRG downloads only report prg_len.
module download_router #(
  parameter int                ADDR_W         = 25,
  parameter logic [ADDR_W-1:0] ROM_START_ADDR = '0,
  parameter logic [ADDR_W-1:0] PRG_START_ADDR = '0,
  parameter logic [ADDR_W-1:0] PTR_PROGND     = '0,
  parameter int                PTR_BYTES      = 2,
  parameter int                FIFO_DEPTH     = 4,
  parameter int                SETTLE_CYCLES  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ioctl_download,
  input  logic [7:0]        ioctl_index,
  input  logic [ADDR_W-1:0] ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  input  logic              ioctl_wr,
  output logic              wr,
  output logic [ADDR_W-1:0] addr,
  output logic [7:0]        data,
  input  logic              wr_ack,
  output logic              downloading,
  output logic              rom_done,
  output logic              overflow,
  output logic [ADDR_W-1:0] prg_len
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, STREAM, DRAIN, PATCH, SETTLE} state_t;

  state_t            state;
  logic [5:0]        index;
  logic [ADDR_W-1:0] len;
  logic [PW-1:0]     rd_ptr, wr_ptr;
  logic [PW:0]       count;
  logic [SW-1:0]     settle_cnt;
  logic              acked;
  logic [1:0]        pidx;
  logic [ADDR_W-1:0] fifo_addr [FIFO_DEPTH];
  logic [7:0]        fifo_data [FIFO_DEPTH];

  logic              push_req, out_free, pop, bypass, fifo_push, drop, ack;
  logic              fifo_empty, fifo_full;
  logic [ADDR_W-1:0] push_addr;
  logic [ADDR_W+31:0] ptr_ext;
  logic [1:0]        pidx_next;
  logic              unused_ext;

  assign unused_ext = ^ioctl_index[7:6];

  // Write port: a transfer happens on every cycle where wr=1 and wr_ack=1; while wr=1 and
  // wr_ack=0, wr/addr/data stay frozen. wr_ack with wr=0 means nothing.
  assign ack        = wr && wr_ack;
  assign out_free   = !wr || wr_ack;
  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == (PW+1)'(FIFO_DEPTH));
  assign push_req   = (state == STREAM) && ioctl_wr && (index == 6'd0 || index == 6'd1);
  assign push_addr  = ((index == 6'd0) ? ROM_START_ADDR : PRG_START_ADDR) + ioctl_addr;
  assign pop        = out_free && !fifo_empty;
  assign bypass     = out_free && fifo_empty && push_req;
  assign fifo_push  = push_req && !bypass && (!fifo_full || pop);
  assign drop       = (ioctl_wr && state != STREAM) || (push_req && !bypass && fifo_full && !pop);
  assign ptr_ext    = {32'd0, PRG_START_ADDR + len};
  assign pidx_next  = pidx + 2'd1;

  always_ff @(posedge clk) begin
    if (fifo_push) begin
      fifo_addr[wr_ptr] <= push_addr;
      fifo_data[wr_ptr] <= ioctl_dout;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      index       <= '0;
      len         <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      settle_cnt  <= '0;
      acked       <= 1'b0;
      pidx        <= '0;
      wr          <= 1'b0;
      addr        <= '0;
      data        <= '0;
      downloading <= 1'b0;
      rom_done    <= 1'b0;
      overflow    <= 1'b0;
      prg_len     <= '0;
    end else begin
      if (fifo_push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)       rd_ptr <= rd_ptr + PW'(1);
      case ({fifo_push, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: ;
      endcase

      // settle_cnt measures cycles since the latest accepted write, saturating at the settle length
      if (ack) begin
        settle_cnt <= '0;
        acked      <= 1'b1;
      end else if (settle_cnt != SETTLE_LAST) begin
        settle_cnt <= settle_cnt + SW'(1);
      end

      if (pop) begin
        wr   <= 1'b1;
        addr <= fifo_addr[rd_ptr];
        data <= fifo_data[rd_ptr];
      end else if (bypass) begin
        wr   <= 1'b1;
        addr <= push_addr;
        data <= ioctl_dout;
      end else if (ack) begin
        wr <= 1'b0;
      end

      case (state)
        IDLE: if (ioctl_download) begin
          index       <= ioctl_index[5:0];
          overflow    <= 1'b0;
          len         <= '0;
          acked       <= 1'b0;
          downloading <= 1'b1;
          state       <= STREAM;
        end
        STREAM: begin
          if (ioctl_wr && index == 6'd1 && ioctl_addr >= len) len <= ioctl_addr + ADDR_W'(1);
          if (!ioctl_download) state <= DRAIN;
        end
        DRAIN: if (fifo_empty && !wr) begin
          if (index == 6'd1) prg_len  <= len;
          if (index == 6'd0) rom_done <= 1'b1;
`ifdef DOWNLOAD_PTR_PATCH_EN
          if (index == 6'd1) begin
            state <= PATCH;
            pidx  <= '0;
            wr    <= 1'b1;
            addr  <= PTR_PROGND;
            data  <= ptr_ext[7:0];
          end else
`endif
          if (!acked) begin
            settle_cnt <= '0;
            state      <= SETTLE;
          end else if (settle_cnt == SETTLE_LAST) begin
            downloading <= 1'b0;
            state       <= IDLE;
          end else begin
            state <= SETTLE;
          end
        end
`ifdef DOWNLOAD_PTR_PATCH_EN
        PATCH: if (ack) begin
          if (pidx == 2'(PTR_BYTES - 1)) begin
            state <= SETTLE;
          end else begin
            pidx <= pidx_next;
            wr   <= 1'b1;
            addr <= PTR_PROGND + ADDR_W'(pidx_next);
            data <= ptr_ext[{pidx_next, 3'b000} +: 8];
          end
        end
`endif
        SETTLE: if (settle_cnt == SETTLE_LAST) begin
          downloading <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if (drop) overflow <= 1'b1;
    end
  end
endmodule
